// File: rtl/alu_mdu_control.sv
// alu_mdu_control
// Multiply/divide control unit that sits beside the EX-stage ALU decoder and
// handles the MIPS HI/LO instruction group (MULT, MULTU, DIV, DIVU, MFHI,
// MFLO, MTHI, MTLO). Multiply and divide run on a shared iterative engine
// that retires one bit per cycle. This block owns HI/LO and stalls the
// pipeline while an operation is in flight.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_start      an R-type instruction is presented in EX this cycle
//   i_funct      funct field of the presented instruction
//   i_operand_a  rs value (multiplicand / dividend / MTHI-MTLO source)
//   i_operand_b  rt value (multiplier / divisor)
//   o_result     HI for MFHI, LO for MFLO, 0 otherwise (combinational)
//   o_stall      presented MDU instruction cannot be accepted this cycle
//   o_busy       engine in RUN or FIXUP
//   o_done       one-cycle pulse, HI/LO hold the new result
//   o_hi, o_lo   HI and LO registers
module alu_mdu_control #(
    parameter int NB_DATA  = 32,
    parameter int NB_FUNCT = 6,
    parameter int NB_CNT   = $clog2(NB_DATA) + 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_FUNCT-1:0] i_funct,
    input  logic [NB_DATA-1:0]  i_operand_a,
    input  logic [NB_DATA-1:0]  i_operand_b,
    output logic [NB_DATA-1:0]  o_result,
    output logic                o_stall,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_DATA-1:0]  o_hi,
    output logic [NB_DATA-1:0]  o_lo
);

    localparam logic [NB_FUNCT-1:0] FN_MFHI  = NB_FUNCT'(6'b010000);
    localparam logic [NB_FUNCT-1:0] FN_MTHI  = NB_FUNCT'(6'b010001);
    localparam logic [NB_FUNCT-1:0] FN_MFLO  = NB_FUNCT'(6'b010010);
    localparam logic [NB_FUNCT-1:0] FN_MTLO  = NB_FUNCT'(6'b010011);
    localparam logic [NB_FUNCT-1:0] FN_MULT  = NB_FUNCT'(6'b011000);
    localparam logic [NB_FUNCT-1:0] FN_MULTU = NB_FUNCT'(6'b011001);
    localparam logic [NB_FUNCT-1:0] FN_DIV   = NB_FUNCT'(6'b011010);
    localparam logic [NB_FUNCT-1:0] FN_DIVU  = NB_FUNCT'(6'b011011);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIXUP, ST_DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NB_CNT-1:0]      cnt;
    logic [2*NB_DATA-1:0]   acc;
    logic [NB_DATA-1:0]     op_reg;
    logic                   op_div;
    logic                   neg_q;
    logic                   neg_rem;
    logic                   div_zero;
    logic [NB_DATA-1:0]     hi_reg;
    logic [NB_DATA-1:0]     lo_reg;

    logic                   is_muldiv;
    logic                   is_mdu;
    logic                   can_accept;
    logic                   accept;
    logic                   start_op;
    logic                   is_signed_op;
    logic                   is_div_funct;
    logic                   sign_a;
    logic                   sign_b;
    logic [NB_DATA-1:0]     mag_a;
    logic [NB_DATA-1:0]     mag_b;
    logic [NB_DATA:0]       mul_sum;
    logic [2*NB_DATA-1:0]   mul_next;
    logic [NB_DATA:0]       rem_shift;
    logic [NB_DATA:0]       diff;
    logic [2*NB_DATA-1:0]   div_next;
    logic [2*NB_DATA-1:0]   prod_fix;
    logic [NB_DATA-1:0]     quot;
    logic [NB_DATA-1:0]     rem;
    logic [NB_DATA-1:0]     fix_hi;
    logic [NB_DATA-1:0]     fix_lo;

    // Instruction decode and acceptance. Only IDLE and DONE can take a new
    // MDU instruction; anything presented in RUN/FIXUP is bounced back via
    // o_stall and has no effect on the engine.
    always_comb begin
        is_muldiv    = (i_funct == FN_MULT) || (i_funct == FN_MULTU) ||
                       (i_funct == FN_DIV)  || (i_funct == FN_DIVU);
        is_mdu       = is_muldiv ||
                       (i_funct == FN_MFHI) || (i_funct == FN_MTHI) ||
                       (i_funct == FN_MFLO) || (i_funct == FN_MTLO);
        can_accept   = (state == ST_IDLE) || (state == ST_DONE);
        accept       = i_start && can_accept;
        start_op     = accept && is_muldiv;
        o_stall      = i_start && is_mdu && !can_accept;
        is_signed_op = (i_funct == FN_MULT) || (i_funct == FN_DIV);
        is_div_funct = (i_funct == FN_DIV) || (i_funct == FN_DIVU);
        sign_a       = is_signed_op && i_operand_a[NB_DATA-1];
        sign_b       = is_signed_op && i_operand_b[NB_DATA-1];
        mag_a        = sign_a ? -i_operand_a : i_operand_a;
        mag_b        = sign_b ? -i_operand_b : i_operand_b;
    end

    // One iteration of each engine. The accumulator holds {partial, operand}:
    // for multiply the low half is the multiplier being shifted out, for
    // divide the low half is the dividend shifting out while quotient bits
    // shift in. A set bit NB_DATA of diff means the trial subtract borrowed.
    always_comb begin
        mul_sum   = {1'b0, acc[2*NB_DATA-1:NB_DATA]} +
                    (acc[0] ? {1'b0, op_reg} : {(NB_DATA+1){1'b0}});
        mul_next  = {mul_sum, acc[NB_DATA-1:1]};
        rem_shift = {acc[2*NB_DATA-1:NB_DATA], acc[NB_DATA-1]};
        diff      = rem_shift - {1'b0, op_reg};
        div_next  = diff[NB_DATA] ?
                    {rem_shift[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0} :
                    {diff[NB_DATA-1:0],      acc[NB_DATA-2:0], 1'b1};
    end

    // Sign correction applied in FIXUP. The remainder follows the dividend's
    // sign, which also makes a signed divide-by-zero return the original
    // dividend in HI. Most-negative / -1 falls out naturally as 100..0 / 0.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quot     = acc[NB_DATA-1:0];
        rem      = acc[2*NB_DATA-1:NB_DATA];
        if (op_div) begin
            fix_lo = div_zero ? {NB_DATA{1'b1}} : (neg_q ? -quot : quot);
            fix_hi = neg_rem ? -rem : rem;
        end else begin
            fix_lo = prod_fix[NB_DATA-1:0];
            fix_hi = prod_fix[2*NB_DATA-1:NB_DATA];
        end
    end

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. RUN lasts exactly NB_DATA cycles as the counter
    // walks from NB_DATA-1 down to 0.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_op) state_next = ST_RUN;
            ST_RUN:   if (cnt == '0) state_next = ST_FIXUP;
            ST_FIXUP: state_next = ST_DONE;
            ST_DONE:  state_next = start_op ? ST_RUN : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Engine datapath: operand magnitudes and result signs are captured on
    // an accepted start, then the accumulator iterates while in RUN.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt      <= '0;
            acc      <= '0;
            op_reg   <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (start_op) begin
            cnt      <= NB_CNT'(NB_DATA - 1);
            op_div   <= is_div_funct;
            neg_q    <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            div_zero <= (i_operand_b == '0);
            if (is_div_funct) begin
                acc    <= {{NB_DATA{1'b0}}, mag_a};
                op_reg <= mag_b;
            end else begin
                acc    <= {{NB_DATA{1'b0}}, mag_b};
                op_reg <= mag_a;
            end
        end else if (state == ST_RUN) begin
            acc <= op_div ? div_next : mul_next;
            if (cnt != '0) begin
                cnt <= cnt - NB_CNT'(1);
            end
        end
    end

    // HI/LO registers: loaded with the corrected result as FIXUP closes, or
    // directly by MTHI/MTLO when accepted.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state == ST_FIXUP) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
        end else if (accept && (i_funct == FN_MTHI)) begin
            hi_reg <= i_operand_a;
        end else if (accept && (i_funct == FN_MTLO)) begin
            lo_reg <= i_operand_a;
        end
    end

    // Outputs. MFHI/MFLO read straight from the registers, so a read in the
    // DONE cycle already sees the fresh result.
    always_comb begin
        o_result = '0;
        if (accept && (i_funct == FN_MFHI)) begin
            o_result = hi_reg;
        end else if (accept && (i_funct == FN_MFLO)) begin
            o_result = lo_reg;
        end
        o_busy = (state == ST_RUN) || (state == ST_FIXUP);
        o_done = (state == ST_DONE);
        o_hi   = hi_reg;
        o_lo   = lo_reg;
    end

endmodule

// File: tb/tb_alu_mdu_control.sv
// tb_alu_mdu_control
// Directed testbench for alu_mdu_control: reset behaviour, MULT/MULTU/DIV/
// DIVU results and latency, divide-by-zero and signed overflow, the MFLO
// hazard stall during an operation, back-to-back starts from DONE, MTHI/MFHI
// and non-MDU funct codes.
module tb_alu_mdu_control;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    logic        i_clock;
    logic        i_reset;
    logic        i_start;
    logic [5:0]  i_funct;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic [31:0] o_result;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int checks_total;
    int checks_passed;

    alu_mdu_control #(
        .NB_DATA  (32),
        .NB_FUNCT (6)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_funct     (i_funct),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .o_result    (o_result),
        .o_stall     (o_stall),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_hi        (o_hi),
        .o_lo        (o_lo)
    );

    // 10 ns clock; inputs change 1 ns after the rising edge.
    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [5:0] funct,
                                 input logic [31:0] a, input logic [31:0] b);
        i_start     = start;
        i_funct     = funct;
        i_operand_a = a;
        i_operand_b = b;
    endtask

    task automatic nextCycle();
        @(posedge i_clock);
        #1;
    endtask

    // Waits (bounded) for o_done starting from the cycle after the start edge
    // and checks the latency: DONE arrives 33 cycles after that first cycle.
    task automatic waitDone(input string tag);
        int cycles;
        cycles = 0;
        while (o_done !== 1'b1 && cycles < 100) begin
            nextCycle();
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'd33);
    endtask

    // Issues one multiply/divide from the current cycle and checks HI/LO in
    // the DONE cycle. Leaves the bench in DONE with inputs idle.
    task automatic runOp(input string tag, input logic [5:0] funct,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        applyStimulus(1'b1, funct, a, b);
        nextCycle();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        checkOutput({tag, " busy"}, 32'(o_busy), 32'd1);
        waitDone(tag);
        checkOutput({tag, " hi"}, o_hi, exp_hi);
        checkOutput({tag, " lo"}, o_lo, exp_lo);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        i_reset = 1'b1;
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        nextCycle();
        nextCycle();
        checkOutput("reset busy", 32'(o_busy), 32'd0);
        checkOutput("reset done", 32'(o_done), 32'd0);
        checkOutput("reset stall", 32'(o_stall), 32'd0);
        checkOutput("reset hi", o_hi, 32'd0);
        checkOutput("reset lo", o_lo, 32'd0);
        i_reset = 1'b0;
        nextCycle();

        // MTHI then MFHI on the following cycle
        applyStimulus(1'b1, FN_MTHI, 32'h12345678, 32'd0);
        nextCycle();
        checkOutput("mthi busy", 32'(o_busy), 32'd0);
        applyStimulus(1'b1, FN_MFHI, 32'd0, 32'd0);
        #1;
        checkOutput("mfhi result", o_result, 32'h12345678);
        checkOutput("mfhi stall", 32'(o_stall), 32'd0);
        nextCycle();

        // Non-MDU funct: ignored, never stalls
        applyStimulus(1'b1, FN_ADD, 32'hDEAD0000, 32'h0000BEEF);
        #1;
        checkOutput("nonmdu stall", 32'(o_stall), 32'd0);
        checkOutput("nonmdu result", o_result, 32'd0);
        nextCycle();
        checkOutput("nonmdu busy", 32'(o_busy), 32'd0);
        checkOutput("nonmdu hi", o_hi, 32'h12345678);
        checkOutput("nonmdu lo", o_lo, 32'd0);

        // Reset in the middle of a MULT
        applyStimulus(1'b1, FN_MTLO, 32'hAAAA5555, 32'd0);
        nextCycle();
        checkOutput("mtlo lo", o_lo, 32'hAAAA5555);
        applyStimulus(1'b1, FN_MULT, 32'd5, 32'd6);
        nextCycle();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        repeat (5) nextCycle();
        checkOutput("midrun busy", 32'(o_busy), 32'd1);
        i_reset = 1'b1;
        #1;
        checkOutput("midreset busy", 32'(o_busy), 32'd0);
        checkOutput("midreset hi", o_hi, 32'd0);
        checkOutput("midreset lo", o_lo, 32'd0);
        nextCycle();
        i_reset = 1'b0;
        applyStimulus(1'b1, FN_MFLO, 32'd0, 32'd0);
        #1;
        checkOutput("postreset mflo", o_result, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);

        // Directed arithmetic vectors
        runOp("mult",     FN_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
        runOp("multu",    FN_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
        runOp("div",      FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divu",     FN_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        applyStimulus(1'b1, FN_MFHI, 32'd0, 32'd0);
        #1;
        checkOutput("divu mfhi done", o_result, 32'd2);
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        runOp("divu0",    FN_DIVU,  32'h00000064, 32'd0,        32'h00000064, 32'hFFFFFFFF);
        runOp("div0",     FN_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        runOp("divovf",   FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // Hazard: MFLO presented from T+5 stalls until DONE at T+34
        applyStimulus(1'b1, FN_MULT, 32'hFFFFFFFD, 32'd7);
        nextCycle();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        repeat (4) nextCycle();
        applyStimulus(1'b1, FN_MFLO, 32'd0, 32'd0);
        for (int k = 5; k <= 33; k++) begin
            @(negedge i_clock);
            checkOutput($sformatf("hazard stall T+%0d", k), 32'(o_stall), 32'd1);
            nextCycle();
        end
        @(negedge i_clock);
        checkOutput("hazard done", 32'(o_done), 32'd1);
        checkOutput("hazard stall done", 32'(o_stall), 32'd0);
        checkOutput("hazard mflo", o_result, 32'hFFFFFFEB);

        // Second start presented in the DONE cycle begins immediately
        applyStimulus(1'b1, FN_MULTU, 32'hFFFFFFFF, 32'd2);
        nextCycle();
        applyStimulus(1'b0, 6'd0, 32'd0, 32'd0);
        checkOutput("b2b busy", 32'(o_busy), 32'd1);
        checkOutput("b2b done low", 32'(o_done), 32'd0);
        waitDone("b2b");
        checkOutput("b2b hi", o_hi, 32'h00000001);
        checkOutput("b2b lo", o_lo, 32'hFFFFFFFE);
        nextCycle();
        checkOutput("idle after done", 32'(o_done), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
